gain_sel_ctrl: RTL and testbench

- Selects, per 160 MHz sample, between the x10 and x1 baseline-subtracted 12-bit channels and forwards one stream to the LiTE-DTU compression/serialiser path.
- On x10 saturation it opens an 8- or 16-sample x1 window that starts PRE samples before the saturated sample; a delay line makes those earlier samples available.
- Sits between the ADC channel interfaces and the encoder.
- Honours GAIN_SEL_MODE and suppresses output while either ADC reports calibration busy.

---
 rtl/gain_sel_ctrl.sv | 113 +++++++++++
 tb/tb_gain_sel_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/gain_sel_ctrl.sv
// Per-sample x10/x1 gain selection ahead of the LiTE-DTU encoder, with a PRE-deep
// look-back delay line. Optional saturation statistics under GAIN_SEL_STATS_EN.
module gain_sel_ctrl #(
  parameter int              DW      = 12,
  parameter int              PRE     = 5,
  parameter logic [DW-1:0]   SAT_THR = DW'(12'hFFF)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    calibration_busy,
  input  logic [1:0]    gain_sel_mode,
  input  logic [DW-1:0] data_g10,
  input  logic [DW-1:0] data_g01,
  output logic [DW-1:0] data_out,
  output logic          gain_flag,
  output logic          data_valid,
  output logic          win_active,
  output logic [15:0]   sat_count
);

  typedef enum logic [1:0] {CAL, FILL, RUN} state_t;

  localparam int FILL_W = 3;

  state_t              state, next_state;
  logic [FILL_W-1:0]   fill_cnt;
  logic [4:0]          win_cnt, win_nxt;
  logic [DW-1:0]       g10_dly [PRE];
  logic [DW-1:0]       g01_dly [PRE];
  logic                busy, sat_eff, sel_x1;

  assign busy = |calibration_busy;

  // Saturation only opens a window in RUN, in a windowed mode, and never while
  // calibration is being requested on the same edge.
  assign sat_eff    = (state == RUN) && !busy && !gain_sel_mode[1] && (data_g10 >= SAT_THR);
  assign sel_x1     = (gain_sel_mode == 2'b11) ||
                      (!gain_sel_mode[1] && (sat_eff || (win_cnt != 5'd0)));
  assign win_active = (win_cnt != 5'd0) || sat_eff;

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    next_state = state;
    win_nxt    = win_cnt;
    case (state)
      CAL:     if (!busy) next_state = FILL;
      FILL:    if (busy) next_state = CAL;
               else if (fill_cnt == FILL_W'(PRE - 1)) next_state = RUN;
      RUN:     if (busy) next_state = CAL;
      default: next_state = CAL;
    endcase

    if ((next_state == CAL) || gain_sel_mode[1]) win_nxt = 5'd0;
    else if (sat_eff)                            win_nxt = gain_sel_mode[0] ? 5'd15 : 5'd7;
    else if (win_cnt != 5'd0)                    win_nxt = win_cnt - 5'd1;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update
  // from the same pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= CAL;
      fill_cnt   <= '0;
      win_cnt    <= '0;
      data_out   <= '0;
      gain_flag  <= 1'b0;
      data_valid <= 1'b0;
      // NOTE: the delay lines are cleared on reset so no pre-reset sample can
      // ever reach the encoder.
      for (int i = 0; i < PRE; i++) begin
        g10_dly[i] <= '0;
        g01_dly[i] <= '0;
      end
    end else begin
      state    <= next_state;
      fill_cnt <= (state == FILL) ? fill_cnt + FILL_W'(1) : '0;
      win_cnt  <= win_nxt;

      g10_dly[0] <= data_g10;
      g01_dly[0] <= data_g01;
      for (int i = 1; i < PRE; i++) begin
        g10_dly[i] <= g10_dly[i-1];
        g01_dly[i] <= g01_dly[i-1];
      end

      // Outputs follow the state being entered, so calibration blanks them at once.
      if (next_state == CAL) begin
        data_out   <= '0;
        gain_flag  <= 1'b0;
        data_valid <= 1'b0;
      end else begin
        data_out   <= sel_x1 ? g01_dly[PRE-1] : g10_dly[PRE-1];
        gain_flag  <= sel_x1;
        data_valid <= (next_state == RUN);
      end
    end
  end

`ifdef GAIN_SEL_STATS_EN
  logic [15:0] sat_cnt;

  always_ff @(posedge clk) begin
    if (!rst)                                sat_cnt <= '0;
    else if (next_state == CAL)              sat_cnt <= '0;
    else if (sat_eff && (sat_cnt != 16'hFFFF)) sat_cnt <= sat_cnt + 16'd1;
  end

  assign sat_count = sat_cnt;
`else
  assign sat_count = 16'h0000;
`endif

endmodule

// File: tb/tb_gain_sel_ctrl.sv
// Directed bench for gain_sel_ctrl: fill latency, windows, forced modes,
// calibration and threshold edges. Honours GAIN_SEL_STATS_EN for sat_count.
module tb_gain_sel_ctrl;

  localparam int DW  = 12;
  localparam int PRE = 5;
`ifdef GAIN_SEL_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    calibration_busy;
  logic [1:0]    gain_sel_mode;
  logic [DW-1:0] data_g10, data_g01, data_out;
  logic          gain_flag, data_valid, win_active;
  logic [15:0]   sat_count;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  // Per-edge record: inputs applied at edge k, outputs seen just after edge k.
  logic [DW-1:0] h10 [1024];
  logic [DW-1:0] h01 [1024];
  logic [DW-1:0] o_data [1024];
  logic          o_flag [1024];
  logic          o_valid [1024];

  gain_sel_ctrl #(.DW(DW), .PRE(PRE), .SAT_THR(12'hFFF)) dut (
    .clk              (clk),
    .rst              (rst),
    .calibration_busy (calibration_busy),
    .gain_sel_mode    (gain_sel_mode),
    .data_g10         (data_g10),
    .data_g01         (data_g01),
    .data_out         (data_out),
    .gain_flag        (gain_flag),
    .data_valid       (data_valid),
    .win_active       (win_active),
    .sat_count        (sat_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] r10(input int k);
    return DW'(16 + (k % 256));
  endfunction

  function automatic logic [DW-1:0] r01(input int k);
    return DW'(1024 + (k % 256));
  endfunction

  task automatic tick(input logic [DW-1:0] g10, input logic [DW-1:0] g01);
    data_g10 = g10;
    data_g01 = g01;
    @(posedge clk);
    h10[cyc] = g10;
    h01[cyc] = g01;
    #1;
    o_data[cyc]  = data_out;
    o_flag[cyc]  = gain_flag;
    o_valid[cyc] = data_valid;
    cyc++;
  endtask

  task automatic ramp(input int n);
    repeat (n) tick(r10(cyc), r01(cyc));
  endtask

  // Sample k leaves on the edge k+PRE; samples wlo..whi must come from x1.
  task automatic check_span(input string tag, input int lo, input int hi,
                            input int wlo, input int whi);
    logic        x1;
    logic [13:0] got, exp;
    for (int k = lo; k <= hi; k++) begin
      x1  = (k >= wlo) && (k <= whi);
      exp = {1'b1, x1, x1 ? h01[k] : h10[k]};
      got = {o_valid[k+PRE], o_flag[k+PRE], o_data[k+PRE]};
      check($sformatf("%s[%0d]", tag, k), 32'(got), 32'(exp));
    end
  endtask

  function automatic int count_x1(input int lo, input int hi);
    int n = 0;
    for (int k = lo; k <= hi; k++) if (o_flag[k+PRE]) n++;
    return n;
  endfunction

  task automatic refill(input string tag);
    for (int i = 1; i <= PRE + 1; i++) begin
      ramp(1);
      check($sformatf("%s_valid%0d", tag, i), 32'(data_valid), 32'(i == PRE + 1));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e1, s, r, m, f, a, b, r2;
    rst = 1'b0;
    calibration_busy = 2'b00;
    gain_sel_mode    = 2'b00;
    data_g10 = '0;
    data_g01 = '0;

    // Reset and fill
    repeat (3) tick(12'hFFF, 12'h123);
    check("rst_data",  32'(data_out),   32'h0);
    check("rst_flag",  32'(gain_flag),  32'h0);
    check("rst_valid", 32'(data_valid), 32'h0);
    check("rst_win",   32'(win_active), 32'h0);
    check("rst_satc",  32'(sat_count),  32'h0);
    rst = 1'b1;
    e1  = cyc;
    refill("fill");
    check("fill_first_data", 32'(data_out),  32'(h10[e1]));
    check("fill_first_flag", 32'(gain_flag), 32'h0);

    // Single saturation, 8-sample window
    ramp(8);
    s = cyc;
    tick(12'hFFF, r01(cyc));
    check("w8_win_active", 32'(win_active), 32'h1);
    check("w8_satc",       32'(sat_count),  STATS ? 32'd1 : 32'd0);
    ramp(14);
    check_span("w8", s - 8, s + 6, s - 5, s + 2);
    check("w8_len", 32'(count_x1(s - 8, s + 6)), 32'd8);

    // Calibration three samples into an open window
    s = cyc;
    tick(12'hFFF, r01(cyc));
    ramp(2);
    calibration_busy = 2'b01;
    ramp(1);
    check("cal_prev_flag", 32'(o_flag[s+2]), 32'h1);
    check("cal_valid",     32'(data_valid),  32'h0);
    check("cal_data",      32'(data_out),    32'h0);
    check("cal_flag",      32'(gain_flag),   32'h0);
    check("cal_win",       32'(win_active),  32'h0);
    check("cal_satc",      32'(sat_count),   32'h0);
    ramp(1);
    check("cal_hold_valid", 32'(data_valid), 32'h0);
    calibration_busy = 2'b00;
    r = cyc;
    refill("cal_refill");
    ramp(12);
    check_span("cal_post", r, r + 8, 1, 0);

    // Retrigger in 16-sample mode
    gain_sel_mode = 2'b01;
    ramp(3);
    s = cyc;
    tick(12'hFFF, r01(cyc));
    ramp(9);
    tick(12'hFFF, r01(cyc));
    ramp(20);
    check_span("w16", s - 7, s + 23, s - 5, s + 20);
    check("w16_len",  32'(count_x1(s - 7, s + 23)), 32'd26);
    check("w16_satc", 32'(sat_count), STATS ? 32'd2 : 32'd0);

    // Forced modes: x10 only with saturated input, then x1 only
    gain_sel_mode = 2'b10;
    f = cyc;
    repeat (10) tick(12'hFFF, r01(cyc));
    check("m10_flag", 32'(gain_flag),  32'h0);
    check("m10_data", 32'(data_out),   32'hFFF);
    check("m10_win",  32'(win_active), 32'h0);
    check_span("m10", f, f + 4, 1, 0);
    gain_sel_mode = 2'b11;
    m = cyc;
    repeat (8) tick(12'hFFF, r01(cyc));
    check_span("m11", m - 8, m + 2, m - 5, m + 2);

    // Threshold boundary
    gain_sel_mode = 2'b00;
    ramp(6);
    a = cyc;
    tick(12'hFFE, r01(cyc));
    check("thr_ffe_win", 32'(win_active), 32'h0);
    ramp(12);
    check_span("thr_ffe", a - 6, a + 6, 1, 0);
    b = cyc;
    tick(12'hFFF, r01(cyc));
    check("thr_fff_win", 32'(win_active), 32'h1);
    ramp(12);
    check_span("thr_fff", b - 6, b + 6, b - 5, b + 2);
    check("thr_fff_len", 32'(count_x1(b - 6, b + 6)), 32'd8);

    // Saturation on the same edge as calibration request
    calibration_busy = 2'b01;
    data_g10 = 12'hFFF;
    data_g01 = r01(cyc);
    #1;
    check("satcal_win_pre", 32'(win_active), 32'h0);
    tick(12'hFFF, r01(cyc));
    check("satcal_valid", 32'(data_valid), 32'h0);
    check("satcal_win",   32'(win_active), 32'h0);
    check("satcal_satc",  32'(sat_count),  32'h0);
    calibration_busy = 2'b00;
    r2 = cyc;
    refill("satcal_refill");
    ramp(12);
    check_span("satcal_post", r2, r2 + 8, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
